// File: rtl/ms5803_comp_seq.sv
// Shared, time-multiplexed MS5803-14BA compensation engine: one 64-bit signed datapath
// serving N_CH channels with run-time loadable PROM coefficients.
module ms5803_comp_seq #(
  parameter int unsigned N_CH         = 3,
  parameter int unsigned CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int unsigned SECOND_ORDER = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            coef_we,
  input  logic [CH_W-1:0] coef_ch,
  input  logic [2:0]      coef_idx,
  input  logic [15:0]     coef_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH_W-1:0] in_ch,
  input  logic [23:0]     in_d1,
  input  logic [23:0]     in_d2,
  output logic            out_valid,
  output logic [CH_W-1:0] out_ch,
  output logic [31:0]     out_temp,
  output logic [31:0]     out_p,
  output logic            out_err
);

  localparam int unsigned NCMP_W = CH_W + 1;
  localparam logic [NCMP_W-1:0] N_CH_CMP = NCMP_W'(N_CH);

  typedef enum logic [3:0] {
    S_IDLE, S_DT, S_TEMP, S_OFF, S_SENS, S_T2, S_OS2, S_ADJ, S_P1, S_P2, S_OUT
  } state_t;

  function automatic logic signed [63:0] zx16(input logic [15:0] v);
    return $signed({48'd0, v});
  endfunction

  function automatic logic signed [63:0] zx24(input logic [23:0] v);
    return $signed({40'd0, v});
  endfunction

  state_t             state, state_nxt;
  logic               accept;
  logic               wr_ok, rd_ch_ok, job_err;
  logic [2:0]         wr_slot;
  logic [CH_W-1:0]    rd_ch;
  logic [15:0]        coef_mem [N_CH][6];
  logic [5:0]         mask_q   [N_CH];
  logic [15:0]        snap     [6];
  logic [5:0]         snap_mask;

  logic [23:0]        d1_q, d2_q;
  logic [CH_W-1:0]    ch_q;
  logic               err_q;
  logic [15:0]        c_q [6];
  logic signed [63:0] dt_q, temp_q, off_q, sens_q, sq_dt_q, sq_tm_q, pm_q;
  logic [31:0]        p_q;
  logic signed [63:0] tm, tl_sq, t2, off2, sens2;

  logic               out_valid_nxt, out_err_nxt;
  logic [CH_W-1:0]    out_ch_nxt;
  logic [31:0]        out_temp_nxt, out_p_nxt;

  assign accept   = in_valid && in_ready;
  assign wr_slot  = coef_idx - 3'd1;
  assign wr_ok    = coef_we && ({1'b0, coef_ch} < N_CH_CMP) && (coef_idx != 3'd0) && (coef_idx != 3'd7);
  assign rd_ch_ok = {1'b0, in_ch} < N_CH_CMP;
  assign rd_ch    = rd_ch_ok ? in_ch : '0;

  // Coefficient storage; contents need no reset, only the loaded mask does
  always_ff @(posedge clk) begin
    if (wr_ok) coef_mem[coef_ch][wr_slot] <= coef_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_q <= '{default: '0};
    else if (wr_ok) mask_q[coef_ch][wr_slot] <= 1'b1;
  end

  // Snapshot view with write-first bypass for a same-edge coefficient write
  always_comb begin
    snap      = coef_mem[rd_ch];
    snap_mask = mask_q[rd_ch];
    if (wr_ok && (coef_ch == in_ch)) begin
      snap[wr_slot]      = coef_data;
      snap_mask[wr_slot] = 1'b1;
    end
  end

  assign job_err = !rd_ch_ok || (snap_mask != 6'h3f);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_DT;
      S_DT:    state_nxt = S_TEMP;
      S_TEMP:  state_nxt = S_OFF;
      S_OFF:   state_nxt = S_SENS;
      S_SENS:  state_nxt = (SECOND_ORDER != 0) ? S_T2 : S_P1;
      S_T2:    state_nxt = S_OS2;
      S_OS2:   state_nxt = S_ADJ;
      S_ADJ:   state_nxt = S_P1;
      S_P1:    state_nxt = S_P2;
      S_P2:    state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Second-order correction terms; (TEMP+1500)^2 is expanded from the (TEMP-2000)^2 square
  always_comb begin
    tm    = temp_q - 64'sd2000;
    tl_sq = sq_tm_q + (64'sd7000 * tm) + 64'sd12250000;
    t2    = '0;
    off2  = '0;
    sens2 = '0;
    if (temp_q < 64'sd2000) begin
      t2    = (64'sd3 * sq_dt_q) >>> 33;
      off2  = (64'sd3 * sq_tm_q) >>> 1;
      sens2 = (64'sd5 * sq_tm_q) >>> 3;
      if (temp_q < -64'sd1500) begin
        off2  = off2 + (64'sd7 * tl_sq);
        sens2 = sens2 + (tl_sq <<< 2);
      end
    end else begin
      t2   = (64'sd7 * sq_dt_q) >>> 37;
      off2 = sq_tm_q >>> 4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q    <= '0;
      d2_q    <= '0;
      ch_q    <= '0;
      err_q   <= 1'b0;
      c_q     <= '{default: '0};
      dt_q    <= '0;
      temp_q  <= '0;
      off_q   <= '0;
      sens_q  <= '0;
      sq_dt_q <= '0;
      sq_tm_q <= '0;
      pm_q    <= '0;
      p_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          d1_q  <= in_d1;
          d2_q  <= in_d2;
          ch_q  <= in_ch;
          err_q <= job_err;
          c_q   <= snap;
        end
        S_DT:   dt_q    <= zx24(d2_q) - (zx16(c_q[4]) <<< 8);
        S_TEMP: temp_q  <= 64'sd2000 + ((dt_q * zx16(c_q[5])) >>> 23);
        S_OFF:  off_q   <= (zx16(c_q[1]) <<< 16) + ((zx16(c_q[3]) * dt_q) >>> 7);
        S_SENS: sens_q  <= (zx16(c_q[0]) <<< 15) + ((zx16(c_q[2]) * dt_q) >>> 8);
        S_T2:   sq_dt_q <= dt_q * dt_q;
        S_OS2:  sq_tm_q <= tm * tm;
        S_ADJ: begin
          temp_q <= temp_q - t2;
          off_q  <= off_q - off2;
          sens_q <= sens_q - sens2;
        end
        S_P1:   pm_q <= (zx24(d1_q) * sens_q) >>> 21;
        S_P2:   p_q  <= 32'((pm_q - off_q) >>> 15);
        default: ;
      endcase
    end
  end

  // Result fields change only with the strobe
  always_comb begin
    out_valid_nxt = 1'b0;
    out_ch_nxt    = out_ch;
    out_err_nxt   = out_err;
    out_temp_nxt  = out_temp;
    out_p_nxt     = out_p;
    if (state == S_OUT) begin
      out_valid_nxt = 1'b1;
      out_ch_nxt    = ch_q;
      out_err_nxt   = err_q;
      out_temp_nxt  = err_q ? 32'd0 : temp_q[31:0];
      out_p_nxt     = err_q ? 32'd0 : p_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_err   <= 1'b0;
      out_temp  <= '0;
      out_p     <= '0;
    end else begin
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= out_valid_nxt;
      out_ch    <= out_ch_nxt;
      out_err   <= out_err_nxt;
      out_temp  <= out_temp_nxt;
      out_p     <= out_p_nxt;
    end
  end

endmodule

// File: doc/ms5803_comp_seq.md
# ms5803_comp_seq

Sequential, multi-channel pressure/temperature compensation engine for MS5803-14BA sensors. It replaces per-channel combinational compensation with one shared 64-bit signed datapath, time-multiplexed across N_CH channels. Coefficients are run-time loadable from the PROM readout rather than hard-coded. Optional second-order temperature compensation is selected by parameter. It sits between the I2C conversion sequencer, which supplies D1/D2 per channel, and the downstream result consumer.

## Interface
- N_CH, 3: number of sensor channels, 1..16.
- CH_W, $clog2(N_CH) min 1: channel index width.
- SECOND_ORDER, 1: 1 enables second-order compensation; 0 selects first-order only.
- clk  in  1  system clock; the single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- coef_we  in  1  coefficient write strobe.
- coef_ch  in  CH_W  channel being written.
- coef_idx  in  3  coefficient number, 1..6 (C1..C6); 0 and 7 are ignored.
- coef_data  in  16  unsigned coefficient value.
- in_valid  in  1  conversion job request.
- in_ready  out  1  engine idle; a job is accepted when in_valid && in_ready.
- in_ch  in  CH_W  job channel.
- in_d1  in  24  unsigned raw pressure.
- in_d2  in  24  unsigned raw temperature.
- out_valid  out  1  one-cycle result strobe.
- out_ch  out  CH_W  channel of the result.
- out_temp  out  32  signed temperature, units of 0.01 °C.
- out_p  out  32  signed pressure, units of 0.1 mbar.
- out_err  out  1  result invalid: channel out of range, or coefficients not fully loaded.

## Operation
- Coefficient RAM: N_CH×6×16 bits, plus a 6-bit loaded mask per channel. A write sets the mask bit. Writes with coef_ch ≥ N_CH are dropped.
- On acceptance, the job snapshots D1, D2, the channel, and that channel's six coefficients into working registers. Coefficient writes after acceptance affect only later jobs, including writes to the active channel.
- All arithmetic is 64-bit two's-complement signed. Every ">>" is an arithmetic shift, which floors toward −∞.
- First-order calculation:
  - dT = D2 − (C5<<8)
  - TEMP = 2000 + (dT·C6 >> 23)
  - OFF = (C2<<16) + (C4·dT >> 7)
  - SENS = (C1<<15) + (C3·dT >> 8)
- Second-order calculation (SECOND_ORDER=1), all terms computed from the first-order TEMP:
  - If TEMP < 2000:
    - T2 = 3·dT² >> 33
    - OFF2 = 3·(TEMP−2000)² >> 1
    - SENS2 = 5·(TEMP−2000)² >> 3
  - If in addition TEMP < −1500:
    - OFF2 += 7·(TEMP+1500)²
    - SENS2 += 4·(TEMP+1500)²
  - If TEMP ≥ 2000:
    - T2 = 7·dT² >> 37
    - OFF2 = (TEMP−2000)² >> 4
    - SENS2 = 0
  - Then TEMP −= T2, OFF −= OFF2, SENS −= SENS2.
- Pressure: P = ((D1·SENS >> 21) − OFF) >> 15.
- Output conversion: out_temp and out_p are the low 32 bits of TEMP and P. There is no saturation; in-spec inputs never exceed range.
- Error job: accepted if in_ch ≥ N_CH, or if the channel's mask ≠ 6'b111111. Such a job completes with the normal latency, with out_err=1 and out_temp = out_p = 0.
- FSM states, one cycle each: IDLE → DT → TEMP → OFF → SENS → [T2 → OS2 → ADJ] → P1 → P2 → OUT → IDLE.
  - The bracketed states exist only when SECOND_ORDER=1.
  - The datapath uses at most one 64×64 multiply per state; squares are taken in T2 and OS2.

## Timing
- Reset: state IDLE; in_ready=1; out_valid=0, out_err=0, out_ch=0, out_temp=0, out_p=0.
- Reset clears all coefficient mask bits; RAM contents are don't-care.
- Acceptance at clock edge k: in_ready drops to 0 after edge k.
- Result: out_valid=1 in the cycle after edge k+LAT.
  - LAT = 10 when SECOND_ORDER=1; LAT = 7 when SECOND_ORDER=0.
  - The IDLE return makes in_ready=1 in that same out_valid cycle. A new job can therefore be accepted on the edge ending the out_valid cycle: throughput is one job per LAT+1 cycles.
- in_valid while in_ready=0: ignored. The requester must hold in_valid and its data until accepted.
- out_ch, out_temp, out_p and out_err update only with out_valid and hold until the next result.
- A coefficient write and an acceptance on the same edge to the same channel/index: the snapshot takes the new value (write-first).
- rst_n asserted mid-job: the job is aborted immediately, no out_valid is produced, and the mask is cleared.

## Test plan
- **dT=0 case.** Load ch0 with C1=44686, C2=40284, C5=32473, C3/C4/C6 arbitrary. Send D2=8313088, D1=4000000. Required: out_temp=2000, out_p=4663, out_err=0, out_valid exactly LAT+1 cycles after acceptance (both SECOND_ORDER settings).
- **Floor rounding and low-temperature second order.** ch1 with C5=32473, C6=28359, D2=8050944 (dT=−262144). Required: first-order TEMP=1113, not 1114. With SECOND_ORDER=1, out_temp=1089 (T2=24). out_p must match the golden model bit-exactly.
- **Error job on an unloaded channel.** Job to ch2 after loading only C1..C5. Required: out_err=1, out_temp=out_p=0, normal latency. Then write C6 and repeat: out_err=0.
- **Out-of-range channel (N_CH=3).** Job with in_ch=3. Required: out_err=1, out_ch=3. A coef write to ch3 must leave ch0..2 unchanged.
- **Back-to-back jobs with snapshot.** ch0 then ch1 with in_valid held high throughout, plus a write of ch0 C2 during job 0. Required: second acceptance on the edge ending job 0's out_valid cycle; job 0 uses the old C2; results are in order with correct out_ch.
- **Reset mid-job.** Assert rst_n at cycle 4 of a job. Required: no out_valid, all outputs 0, in_ready=1 after release, and a subsequent job returns out_err=1 until coefficients are reloaded.
